// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: buffered I2S transmitter for the WM8731 DAC path.
// Optional macro: I2S_TX_HOLD_LAST_EN (repeat last pair on underrun).
module i2s_dac_tx #(
  parameter int DEPTH = 8
) (
  input  logic                     i_bclk,
  input  logic                     i_rst_n,
  input  logic                     i_daclrck,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [15:0]              i_left,
  input  logic [15:0]              i_right,
  output logic                     o_dacdat,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_underrun,
  input  logic                     i_clr_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          lrck_q;
  logic          armed;
  logic [15:0]   hold_r;
  logic [15:0]   shreg;
  logic [4:0]    cnt;

  logic          lr_edge;
  logic          fall;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   pair;
  logic [31:0]   fill;
  logic [31:0]   new_pair;
  logic [15:0]   word;
  logic [LW-1:0] level_nxt;

`ifdef I2S_TX_HOLD_LAST_EN
  logic [15:0]   hold_l;
  assign fill = {hold_l, hold_r};
`else
  assign fill = 32'd0;
`endif

  // Edge detect, FIFO handshakes and word selection
  always_comb begin
    lr_edge   = armed && (i_daclrck != lrck_q);
    fall      = lr_edge && !i_daclrck;
    empty     = (o_level == '0);
    push      = i_valid && o_ready;
    pop       = fall && !empty;
    pair      = mem[rd_ptr];
    new_pair  = pop ? pair : fill;
    word      = fall ? new_pair[31:16] : hold_r;
    level_nxt = o_level;
    if (push && !pop)
      level_nxt = o_level + LW'(1);
    else if (pop && !push)
      level_nxt = o_level - LW'(1);
  end

  // FIFO storage; contents are discarded by the pointer reset
  always_ff @(posedge i_bclk) begin
    if (push)
      mem[wr_ptr] <= {i_left, i_right};
  end

  // FIFO pointers, level and ready
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
      o_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      o_level <= level_nxt;
      o_ready <= (level_nxt != FULL);
    end
  end

  // LRCK tracking, held pair and sticky underrun
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_q     <= 1'b0;
      armed      <= 1'b0;
      hold_r     <= '0;
`ifdef I2S_TX_HOLD_LAST_EN
      hold_l     <= '0;
`endif
      o_underrun <= 1'b0;
    end else begin
      lrck_q <= i_daclrck;
      armed  <= 1'b1;
      if (fall) begin
        hold_r <= new_pair[15:0];
`ifdef I2S_TX_HOLD_LAST_EN
        hold_l <= new_pair[31:16];
`endif
      end
      if (fall && empty)
        o_underrun <= 1'b1;
      else if (i_clr_underrun)
        o_underrun <= 1'b0;
    end
  end

  // MSB-first shifter; idles at 16 with the line low
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg    <= '0;
      cnt      <= 5'd16;
      o_dacdat <= 1'b0;
    end else if (lr_edge) begin
      o_dacdat <= word[15];
      shreg    <= {word[14:0], 1'b0};
      cnt      <= 5'd1;
    end else if (cnt != 5'd16) begin
      o_dacdat <= shreg[15];
      shreg    <= {shreg[14:0], 1'b0};
      cnt      <= cnt + 5'd1;
    end else begin
      o_dacdat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: randomized bench for i2s_dac_tx
// against a queue-based model of the I2S frame rules.
module tb_i2s_dac_tx;

  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lrck;
  logic          valid;
  logic          clr;
  logic [15:0]   left;
  logic [15:0]   right;
  logic          o_ready;
  logic          o_dacdat;
  logic [LW-1:0] o_level;
  logic          o_underrun;

  int tests = 0;
  int fails = 0;

  i2s_dac_tx #(.DEPTH(DEPTH)) dut (
    .i_bclk         (clk),
    .i_rst_n        (rst_n),
    .i_daclrck      (lrck),
    .i_valid        (valid),
    .o_ready        (o_ready),
    .i_left         (left),
    .i_right        (right),
    .o_dacdat       (o_dacdat),
    .o_level        (o_level),
    .o_underrun     (o_underrun),
    .i_clr_underrun (clr)
  );

  always #5 clk = ~clk;

  // reference model: queue of pairs, word on air, cycles since edge
  logic [31:0] mq [$];
  logic [15:0] m_l, m_r, m_word;
  int          m_k;
  bit          m_armed;
  logic        m_lrck;
  bit          m_under;

  function automatic logic [LW+2:0] exp_vec();
    logic d;
    d = (m_k < 16) ? m_word[15 - m_k] : 1'b0;
    return {d, mq.size() < DEPTH, LW'(mq.size()), m_under};
  endfunction

  function automatic logic [LW+2:0] act_vec();
    return {o_dacdat, o_ready, o_level, o_underrun};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_l = '0; m_r = '0; m_word = '0;
    m_k = 16; m_armed = 0; m_lrck = 1'b0; m_under = 0;
  endtask

  // drive one BCLK cycle and advance the model to match
  task automatic step(input bit v, input logic [15:0] l,
                      input logic [15:0] r, input bit lr,
                      input bit c);
    bit push, empty, ed;
    logic [31:0] p;
    p = '0;
    valid = v; left = l; right = r; lrck = lr; clr = c;
    empty = (mq.size() == 0);
    push = v && (mq.size() < DEPTH);
    ed = m_armed && (lr != m_lrck);
    if (ed && !lr) begin
      if (!empty) p = mq.pop_front();
      else begin
        m_under = 1;
`ifdef I2S_TX_HOLD_LAST_EN
        p = {m_l, m_r};
`else
        p = '0;
`endif
      end
      m_l = p[31:16]; m_r = p[15:0];
      m_word = m_l; m_k = 0;
    end else if (ed) begin
      m_word = m_r; m_k = 0;
    end else if (m_k < 16) begin
      m_k++;
    end
    if (c && !(ed && !lr && empty)) m_under = 0;
    if (push) mq.push_back({l, r});
    m_lrck = lr; m_armed = 1;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit lr);
    rst_n = 1'b0; lrck = lr; valid = 1'b0; clr = 1'b0;
    left = '0; right = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    tests++;
    if (o_dacdat !== 1'b0) begin fails++; $display("FAIL reset_dacdat got %b want 0", o_dacdat); end
    tests++;
    if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", o_ready); end
    tests++;
    if (o_level !== '0) begin fails++; $display("FAIL reset_level got %0d want 0", o_level); end
    tests++;
    if (o_underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b want 0", o_underrun); end
  endtask

  task automatic test_basic();
    logic [15:0] gl, gr;
    gl = '0; gr = '0;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(1, 16'h8001, 16'h7FFE, 1, 0);
    tests++;
    if (o_level !== LW'(1)) begin fails++; $display("FAIL basic_level1 got %0d want 1", o_level); end
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0);
      if (i < 16) gl[15 - i] = o_dacdat;
      if (i == 0) begin
        tests++;
        if (o_level !== '0) begin fails++; $display("FAIL basic_level0 got %0d want 0", o_level); end
      end
      tests++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL basic_left t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
    end
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 1, 0);
      if (i < 16) gr[15 - i] = o_dacdat;
      tests++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL basic_right t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
    end
    tests++;
    if (gl !== 16'h8001) begin fails++; $display("FAIL basic_lword got %h want 8001", gl); end
    tests++;
    if (gr !== 16'h7FFE) begin fails++; $display("FAIL basic_rword got %h want 7ffe", gr); end
  endtask

  task automatic test_fill();
    do_reset(1'b1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 16'($urandom), 16'($urandom), 1, 0);
      tests++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL fill_push t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
    end
    tests++;
    if (o_ready !== 1'b0 || o_level !== LW'(DEPTH)) begin
      fails++; $display("FAIL fill_full got rdy=%b lvl=%0d want rdy=0 lvl=%0d", o_ready, o_level, DEPTH);
    end
    step(1, 16'($urandom), 16'($urandom), 0, 0);
    tests++;
    if (o_level !== LW'(DEPTH - 1)) begin fails++; $display("FAIL fill_reject got %0d want %0d", o_level, DEPTH - 1); end
    for (int f = 0; f < 2 * DEPTH; f++) begin
      for (int i = (f == 0) ? 1 : 0; i < 32; i++) begin
        step(0, 0, 0, f[0] ? 1'b0 : 1'b1, 0);
        tests++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL fill_order t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
      end
    end
  endtask

  task automatic test_underrun();
    do_reset(1'b1);
    step(0, 0, 0, 1, 0);
    step(1, 16'hA5C3, 16'h3C5A, 1, 0);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 32; i++) begin
        step(0, 0, 0, f[0], 0);
        if (f == 2 && i == 0) begin
          tests++;
          if (o_underrun !== 1'b1) begin fails++; $display("FAIL under_set got %b want 1", o_underrun); end
        end
        tests++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL under_data t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
      end
    end
    step(0, 0, 0, 1, 1);
    tests++;
    if (o_underrun !== 1'b0) begin fails++; $display("FAIL under_clr got %b want 0", o_underrun); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    tests++;
    if (o_underrun !== 1'b1) begin fails++; $display("FAIL under_setwins got %b want 1", o_underrun); end
    step(0, 0, 0, 0, 1);
    tests++;
    if (act_vec() !== exp_vec()) begin fails++; $display("FAIL under_clr2 got %b want %b", act_vec(), exp_vec()); end
  endtask

  task automatic test_first_cycle();
    logic [15:0] l0, gl, gr;
    l0 = 16'($urandom) | 16'h8000;
    gl = '0; gr = 16'hFFFF;
    do_reset(1'b1);
    step(1, l0, 16'($urandom), 0, 0);
    tests++;
    if (o_underrun !== 1'b0) begin fails++; $display("FAIL first_noedge got %b want 0", o_underrun); end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 1, 0);
      if (i < 16) gr[15 - i] = o_dacdat;
      tests++;
      if (act_vec() !== exp_vec()) begin fails++; $display("FAIL first_right t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
    end
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0);
      if (i < 16) gl[15 - i] = o_dacdat;
    end
    tests++;
    if (gr !== 16'h0000) begin fails++; $display("FAIL first_rzero got %h want 0000", gr); end
    tests++;
    if (gl !== l0) begin fails++; $display("FAIL first_ldata got %h want %h", gl, l0); end
  endtask

  task automatic test_short();
    do_reset(1'b0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 10; i++) begin
        step(0, 0, 0, f[0] ? 1'b0 : 1'b1, 0);
        tests++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL short t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 16'($urandom), 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    tests++;
    if (o_level !== LW'(3)) begin fails++; $display("FAIL mid_level3 got %0d want 3", o_level); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (o_dacdat !== 1'b0 || o_level !== '0) begin
      fails++; $display("FAIL mid_reset got d=%b lvl=%0d want d=0 lvl=0", o_dacdat, o_level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
    for (int f = 0; f < 7; f++) begin
      for (int i = 0; i < 32; i++) begin
        step(0, 0, 0, f[0] ? 1'b0 : 1'b1, 0);
        tests++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL mid_after t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
      end
    end
  endtask

  task automatic test_random();
    bit lr;
    int len;
    lr = 1'($urandom);
    do_reset(lr);
    for (int f = 0; f < 60; f++) begin
      lr = ~lr;
      len = $urandom_range(40, 8);
      for (int i = 0; i < len; i++) begin
        step($urandom_range(9, 0) == 0, 16'($urandom), 16'($urandom),
             lr, $urandom_range(30, 0) == 0);
        tests++;
        if (act_vec() !== exp_vec()) begin fails++; $display("FAIL random t=%0t got %b want %b", $time, act_vec(), exp_vec()); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; lrck = 1'b1; valid = 1'b0; clr = 1'b0;
    left = '0; right = '0;
    model_reset();
    test_reset();
    test_basic();
    test_fill();
    test_underrun();
    test_first_cycle();
    test_short();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Buffered I2S transmitter for the WM8731 DAC path: the transmit-side counterpart of the ADC `Listen` receiver. It accepts stereo 16-bit sample pairs through a valid/ready FIFO and serializes them onto `AUD_DACDAT`, with the codec acting as bit/frame clock master (`AUD_BCLK`, `AUD_DACLRCK`). It sits between the synthesizer/playback logic and the codec pins, and is held in reset until `SetCodec` reports init finished.

## Interface
- `DEPTH`, 8: FIFO depth in stereo pairs; power of two, 2..64.
- `i_bclk`  in  1  codec bit clock `AUD_BCLK`; all registers on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_daclrck`  in  1  `AUD_DACLRCK`; 0 = left, 1 = right.
- `i_valid`  in  1  write request.
- `o_ready`  out  1  FIFO not full.
- `i_left`  in  16  signed left sample.
- `i_right`  in  16  signed right sample.
- `o_dacdat`  out  1  serial data to `AUD_DACDAT`.
- `o_level`  out  $clog2(DEPTH)+1  pairs currently stored.
- `o_underrun`  out  1  sticky; set when a left frame starts with the FIFO empty.
- `i_clr_underrun`  in  1  synchronous clear of `o_underrun`.

## Operation
- Reset values: `o_dacdat`=0, `o_ready`=1, `o_level`=0, `o_underrun`=0; FIFO empty; bit counter idle; held pair = {0,0}; `armed`=0.
- Write: a pair is pushed on a rising edge with `i_valid && o_ready`. `o_ready` = !full, computed from the registered level. A pop in the same cycle does not make a full FIFO accept a write.
- LRCK tracking: `lrck_q` samples `i_daclrck` every cycle. The first cycle after reset only loads `lrck_q` and sets `armed`; no edge is detected in that cycle. An edge is detected when `armed && i_daclrck != lrck_q`.
- Falling edge (left frame start):
  - FIFO non-empty: pop one pair into the shift/hold registers.
  - FIFO empty: set `o_underrun`, and load the underrun pair (see Configuration).
  - Load the left word into the shifter.
- Rising edge (right frame start): load the held right word into the shifter.
- Right frame before any left frame after reset: the shifter is loaded with 0. The block starts transmitting real data only at the first detected falling edge.
- Serialization:
  - On an edge cycle n, `o_dacdat` <= bit 15 (MSB).
  - Cycles n+1..n+15 shift out bits 14..0.
  - From n+16 until the next edge, `o_dacdat` = 0.
  - The 5-bit counter saturates at 16.
- Short frame: an LRCK edge arriving before 16 bits complete restarts the shifter for the new channel. The truncated word is dropped with no error.
- Push and pop in the same cycle: the level is unchanged. Push into an empty FIFO while a pop is attempted: the pop sees empty (underrun), and the pushed pair is stored.
- `i_clr_underrun` in the same cycle as a new underrun: set wins.
- Pointers: `$clog2(DEPTH)` bits, wrap naturally. `o_level` is a separate counter, incremented or decremented per push/pop.
- Reset asserted mid-frame: all state returns to reset values immediately and the FIFO contents are discarded.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- I2S alignment: LRCK changes on the falling BCLK edge, and the first rising edge after it is cycle n. The MSB driven at n is sampled by the codec at n+1 (second rising edge after the LRCK change), as required by I2S mode.
- Write-to-air latency from an empty FIFO: a pair pushed at cycle w is popped at the next falling-LRCK edge detected at a cycle after w. Its MSB is on `o_dacdat` at that same edge.
- `o_ready` and `o_level` update one cycle after a push or pop.
- Throughput: one pair per LRCK period (32 or more BCLK per channel).

## Configuration
- `I2S_TX_HOLD_LAST_EN` defined: on underrun, the last successfully popped pair is retransmitted. After reset with no prior pop, this is {0,0}.
- `I2S_TX_HOLD_LAST_EN` undefined: on underrun, the pair {0,0} (silence) is transmitted.
- `o_underrun` behaves identically in both builds.

## Test plan
- Push {16'h8001, 16'h7FFE}, then drive LRCK 1→0 with 32 BCLK per channel. Expect left bits 1000_0000_0000_0001 on cycles n..n+15, then zeros. After LRCK 0→1, expect 0111_1111_1111_1110. `o_level` goes 1→0.
- Push 8 pairs with `DEPTH`=8 and no LRCK edges: `o_ready`=0 and `o_level`=8. A 9th `i_valid` in the same cycle as a pop is rejected. Data order is preserved over the next 8 frames.
- Empty FIFO plus a falling LRCK edge: `o_underrun`=1 the next cycle. The DAC outputs 16 zeros, or the last pair with `I2S_TX_HOLD_LAST_EN`. `i_clr_underrun` clears the flag.
- Release reset while LRCK=1, then a 1→0 change: no edge in the first cycle. The right slot outputs zeros, and the first data appears in the left slot.
- LRCK toggles after only 10 BCLK: the shifter restarts and the MSB of the new channel appears at the edge cycle.
- Assert `i_rst_n`=0 at bit 7 of a left word with 3 pairs queued: `o_dacdat`=0 and `o_level`=0 immediately. After release, 3 new pushes transmit correctly.
